// File: rtl/sub72_seq_pkg.sv
// Shared constants and FSM encoding for the sequential 72-bit subtractor.
// Holds the default operand/slice widths, the derived slice count and the
// slice index width, and the IDLE/RUN/DONE state type used by sub72_seq.
package sub72_seq_pkg;

    localparam int WIDTH  = 72;
    localparam int CHUNK  = 24;
    localparam int NCHUNK = WIDTH / CHUNK;
    // One-slice configurations still need a 1-bit index register.
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub72_seq_if.sv
// Operand/result handshake bundle for sub72_seq.
// slave : subtractor side (consumes operands, produces d/bout/ovf).
// master: producer/consumer side (drives operands and out_ready).
interface sub72_seq_if #(
    parameter int WIDTH = sub72_seq_pkg::WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:1]   a;
    logic [WIDTH:1]   b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:1]   d;
    logic             bout;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, d, bout, ovf
    );

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, d, bout, ovf
    );
endinterface

// File: rtl/sub72_seq_sub_chunk.sv
// Combinational CHUNK-bit subtract with borrow: diff = x - y - bi.
// Ports: i_x, i_y (slice operands), i_bi (borrow in);
//        o_diff (slice difference), o_bo (borrow out, 1 iff x < y + bi).
module sub72_seq_sub_chunk #(
    parameter int CHUNK = sub72_seq_pkg::CHUNK
) (
    input  logic [CHUNK-1:0] i_x,
    input  logic [CHUNK-1:0] i_y,
    input  logic             i_bi,
    output logic [CHUNK-1:0] o_diff,
    output logic             o_bo
);
    logic [CHUNK:0] w_full;

    // One extra bit of headroom: the top bit goes to 1 exactly when the
    // slice result is negative, which is the borrow out.
    assign w_full = {1'b0, i_x} - {1'b0, i_y} - {{CHUNK{1'b0}}, i_bi};
    assign o_diff = w_full[CHUNK-1:0];
    assign o_bo   = w_full[CHUNK];
endmodule

// File: rtl/sub72_seq.sv
// Multi-cycle WIDTH-bit subtractor d = a - b - bin, one CHUNK slice per cycle.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries the
//        in_valid/in_ready operand handshake and out_valid/out_ready result.
// Latency: accept -> out_valid after WIDTH/CHUNK RUN cycles; no overlap.
module sub72_seq #(
    parameter int WIDTH = sub72_seq_pkg::WIDTH,
    parameter int CHUNK = sub72_seq_pkg::CHUNK
) (
    input  logic         clk,
    input  logic         rst,
    sub72_seq_if.slave   bus
);
    import sub72_seq_pkg::*;

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_width
        $fatal(1, "sub72_seq: WIDTH must be an integer multiple of CHUNK");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_in_ready;
    logic               w_out_valid;

    logic [WIDTH:1]     r_a;
    logic [WIDTH:1]     r_b;
    logic [WIDTH:1]     r_d;
    logic               r_borrow;
    logic [IDX_W-1:0]   r_idx;
    logic               r_bout;
    logic               r_ovf;

    logic [CHUNK-1:0]   w_x;
    logic [CHUNK-1:0]   w_y;
    logic [CHUNK-1:0]   w_diff;
    logic               w_bo;
    logic               w_last;

    // Current slice of each operand; the single slice subtractor is
    // time-shared across all slices.
    assign w_x    = r_a[int'(r_idx) * CHUNK + 1 +: CHUNK];
    assign w_y    = r_b[int'(r_idx) * CHUNK + 1 +: CHUNK];
    assign w_last = (r_idx == LAST_IDX);

    sub72_seq_sub_chunk #(.CHUNK(CHUNK)) u_sub_chunk (
        .i_x    (w_x),
        .i_y    (w_y),
        .i_bi   (r_borrow),
        .o_diff (w_diff),
        .o_bo   (w_bo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_d      <= '0;
            r_borrow <= 1'b0;
            r_idx    <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_borrow <= bus.bin;
                        r_idx    <= '0;
                    end
                end
                S_RUN: begin
                    r_d[int'(r_idx) * CHUNK + 1 +: CHUNK] <= w_diff;
                    r_borrow <= w_bo;
                    r_idx    <= r_idx + 1'b1;
                    if (w_last) begin
                        // w_diff holds the top slice here, so its MSB is d's sign.
                        r_bout <= w_bo;
                        r_ovf  <= (r_a[WIDTH] != r_b[WIDTH]) &&
                                  (w_diff[CHUNK-1] != r_a[WIDTH]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.d         = r_d;
    assign bus.bout      = r_bout;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_sub72_seq.sv
// Bench for sub72_seq: directed corner cases plus randomized operands with
// random result backpressure, scored against a plain-arithmetic model.
module tb_sub72_seq;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   n_sent = 0;
    int   n_results = 0;
    bit   rand_bp = 1'b0;

    logic [73:0] exp_q[$];
    int          acc_q[$];

    sub72_seq_if bus ();

    sub72_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {bout, ovf, d}
    function automatic logic [73:0] model(input logic [71:0] a, input logic [71:0] b,
                                          input logic bin);
        logic [71:0] d;
        logic        bo;
        logic        ov;
        d  = a - b - {71'd0, bin};
        bo = ({2'b00, a} < ({2'b00, b} + {73'd0, bin}));
        ov = (a[71] != b[71]) && (d[71] != a[71]);
        return {bo, ov, d};
    endfunction

    task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        logic        prev_ov;
        logic        prev_hs;
        logic [73:0] held;
        logic [73:0] act;
        prev_ov = 1'b0;
        prev_hs = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                acc_q.delete();
                prev_ov = 1'b0;
                prev_hs = 1'b0;
            end else begin
                act = {bus.bout, bus.ovf, bus.d};
                if (bus.in_valid && bus.in_ready) begin
                    exp_q.push_back(model(bus.a, bus.b, bus.bin));
                    acc_q.push_back(cyc);
                end
                if (bus.out_valid) begin
                    chk("in_ready_low_while_valid", {73'd0, bus.in_ready}, 74'd0);
                    if (!prev_ov) begin
                        if (acc_q.size() == 0) begin
                            chk("unexpected_out_valid", 74'd1, 74'd0);
                        end else begin
                            chk("latency", 74'(cyc - acc_q.pop_front()), 74'(LAT));
                        end
                    end else if (!prev_hs) begin
                        chk("result_stable_under_backpressure", act, held);
                    end else begin
                        chk("out_valid_after_handshake", 74'd1, 74'd0);
                    end
                    held = act;
                end else if (prev_ov && !prev_hs) begin
                    chk("out_valid_dropped_without_handshake", 74'd0, 74'd1);
                end
                if (bus.out_valid && bus.out_ready) begin
                    n_results++;
                    if (exp_q.size() == 0) begin
                        chk("result_without_operands", 74'd1, 74'd0);
                    end else begin
                        chk("result", act, exp_q.pop_front());
                    end
                end
                prev_ov = bus.out_valid;
                prev_hs = bus.out_valid && bus.out_ready;
            end
        end
    end

    // Random result backpressure
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_bp) bus.out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [71:0] a, input logic [71:0] b, input logic bin);
        int n;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.bin      = bin;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 74'd1, 74'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = {$urandom, $urandom, $urandom};
        bus.b        = {$urandom, $urandom, $urandom};
        bus.bin      = 1'($urandom);
        n_sent++;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 74'd1, 74'd0);
        @(negedge clk);
    endtask

    initial begin
        int n;
        logic [71:0] ra;
        logic [71:0] rb;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready",  {73'd0, bus.in_ready},  74'd1);
        chk("reset_out_valid", {73'd0, bus.out_valid}, 74'd0);
        chk("reset_d",         {2'b00, bus.d},         74'd0);
        chk("reset_bout",      {73'd0, bus.bout},      74'd0);
        chk("reset_ovf",       {73'd0, bus.ovf},       74'd0);

        // Directed corner cases
        send(72'd5, 72'd3, 1'b0);
        wait_idle();
        send(72'd0, 72'd1, 1'b0);
        wait_idle();
        send(72'h000000_000001_000000, 72'd1, 1'b0);
        wait_idle();
        send(72'h123456_789ABC_DEF012, 72'h123456_789ABC_DEF012, 1'b1);
        wait_idle();
        send(72'h7FFFFF_FFFFFF_FFFFFF, 72'hFFFFFF_FFFFFF_FFFFFF, 1'b0);
        wait_idle();
        send(72'h800000_000000_000000, 72'h000000_000000_000000, 1'b1);
        wait_idle();

        // Backpressure: hold result 5 cycles while new operands wait
        bus.out_ready = 1'b0;
        send(72'hABCDEF_012345_678901, 72'h00000F_FFFFFF_FFFFFF, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_seen", {73'd0, bus.out_valid}, 74'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.a        = 72'h000000_FFFFFF_000000;
        bus.b        = 72'h000001_000000_000001;
        bus.bin      = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
        send(72'h000000_FFFFFF_000000, 72'h000001_000000_000001, 1'b0);
        wait_idle();

        // Reset during the second RUN cycle
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.a        = 72'd7;
        bus.b        = 72'd2;
        bus.bin      = 1'b0;
        @(negedge clk);
        chk("abort_op_accepted", {73'd0, bus.in_ready}, 74'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrun_reset_out_valid", {73'd0, bus.out_valid}, 74'd0);
        chk("midrun_reset_in_ready",  {73'd0, bus.in_ready},  74'd1);
        chk("midrun_reset_d",         {2'b00, bus.d},         74'd0);
        send(72'd10, 72'd4, 1'b0);
        wait_idle();

        // Randomized operands with random result backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom};
            case ($urandom_range(0, 5))
                0: rb = ra;
                1: ra = '1;
                2: rb = '1;
                3: ra[47:0] = '0;
                default: ;
            endcase
            send(ra, rb, 1'($urandom));
        end
        wait_idle();
        rand_bp = 1'b0;
        bus.out_ready = 1'b1;
        wait_idle();

        chk("result_count", 74'(n_results), 74'(n_sent));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
